// File: rtl/vga_text_pkg.sv
// Shared constants and types for the VGA text-mode VRAM arbiter.
// The return-tag struct follows each RAM access through the two-stage return pipeline.
package vga_text_pkg;

  localparam int COLS         = 70;
  localparam int ROWS         = 30;
  localparam int ADDR_W       = 12;
  localparam int CELL_W       = 9;
  localparam int CELL_H       = 16;
  localparam int BLINK_FRAMES = 30;

  localparam logic [7:0] SPACE_CODE = 8'h20;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_SCAN,
    ACC_CPU_RD,
    ACC_CPU_WR
  } acc_t;

  typedef struct packed {
    acc_t acc;
    logic oor;   // access was out of range, so the RAM was not enabled
    logic hit;   // scan access matched the visible cursor cell
  } ret_tag_t;

  localparam ret_tag_t TAG_IDLE = '{acc: ACC_NONE, oor: 1'b0, hit: 1'b0};

endpackage

// File: rtl/vga_cursor_blink.sv
// Cursor blink timer: counts frame_start pulses and toggles cursor_on
// every BLINK_FRAMES frames.
module vga_cursor_blink #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic pclk,
  input  logic reset,
  input  logic frame_start_i,
  output logic cursor_on_o
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             cursor_on_q, cursor_on_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    cursor_on_d = cursor_on_q;
    if (frame_start_i) begin
      if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        cursor_on_d = !cursor_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
      cursor_on_q <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      cursor_on_q <= cursor_on_d;
    end
  end

  assign cursor_on_o = cursor_on_q;

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: scan fetches have strict priority, CPU accesses fill idle
// slots. Fixed latencies: scan data 3 cycles after scan_req, CPU read data 2 after cpu_gnt.
module vga_vram_arbiter #(
  parameter int         COLS         = vga_text_pkg::COLS,
  parameter int         ROWS         = vga_text_pkg::ROWS,
  parameter int         ADDR_W       = vga_text_pkg::ADDR_W,
  parameter int         BLINK_FRAMES = vga_text_pkg::BLINK_FRAMES,
  parameter logic [7:0] SPACE_CODE   = vga_text_pkg::SPACE_CODE
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              scan_req,
  input  logic [4:0]        scan_row,
  input  logic [6:0]        scan_col,
  output logic [7:0]        scan_data,
  output logic              scan_vld,
  output logic              cursor_hit,
  output logic              scan_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_gnt,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rvalid,
  input  logic [ADDR_W-1:0] cursor_pos,
  input  logic              frame_start,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  import vga_text_pkg::*;

  localparam int CELLS = COLS * ROWS;

  logic              cursor_on;
  logic              scan_in_range, cpu_in_range;
  logic [ADDR_W-1:0] scan_lin;
  logic              issue_scan, issue_cpu;

  logic              scan_pend_q, scan_pend_d;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic              scan_inr_q, scan_inr_d;
  logic              scan_overrun_q, scan_overrun_d;

  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              cpu_gnt_q, cpu_gnt_d;

  ret_tag_t          tag1_q, tag1_d;
  ret_tag_t          tag2_q, tag2_d;

  logic [7:0]        scan_data_q, scan_data_d;
  logic              scan_vld_q, scan_vld_d;
  logic              cursor_hit_q, cursor_hit_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;

  vga_cursor_blink #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .pclk          (pclk),
    .reset         (reset),
    .frame_start_i (frame_start),
    .cursor_on_o   (cursor_on)
  );

  assign scan_in_range = (int'(scan_row) < ROWS) && (int'(scan_col) < COLS);
  assign scan_lin      = ADDR_W'(int'(scan_row) * COLS + int'(scan_col));
  assign cpu_in_range  = int'(cpu_addr) < CELLS;

  // A scan_req arriving this cycle blocks the CPU too, so the scan gets the next slot.
  assign issue_scan = scan_pend_q && !scan_req;
  assign issue_cpu  = cpu_req && !scan_pend_q && !scan_req;

  always_comb begin
    // NOTE: every variable gets a default first so no latch can be inferred.
    scan_pend_d    = scan_pend_q;
    scan_addr_d    = scan_addr_q;
    scan_inr_d     = scan_inr_q;
    scan_overrun_d = scan_overrun_q;
    ram_en_d       = 1'b0;
    ram_we_d       = 1'b0;
    ram_addr_d     = '0;
    ram_wdata_d    = '0;
    cpu_gnt_d      = 1'b0;
    tag1_d         = TAG_IDLE;
    tag2_d         = tag1_q;
    scan_data_d    = scan_data_q;
    scan_vld_d     = 1'b0;
    cursor_hit_d   = 1'b0;
    cpu_rdata_d    = cpu_rdata_q;
    cpu_rvalid_d   = 1'b0;

    if (issue_scan) scan_pend_d = 1'b0;

    // A newer request replaces a still-pending one; only the newer one returns data.
    if (scan_req) begin
      scan_pend_d    = 1'b1;
      scan_addr_d    = scan_lin;
      scan_inr_d     = scan_in_range;
      scan_overrun_d = scan_overrun_q | scan_pend_q;
    end

    if (issue_scan) begin
      ram_en_d   = scan_inr_q;
      ram_addr_d = scan_addr_q;
      tag1_d     = '{acc: ACC_SCAN, oor: !scan_inr_q,
                     hit: (scan_addr_q == cursor_pos) && cursor_on};
    end else if (issue_cpu) begin
      cpu_gnt_d   = 1'b1;
      ram_en_d    = cpu_in_range;
      ram_we_d    = cpu_we && cpu_in_range;
      ram_addr_d  = cpu_addr;
      ram_wdata_d = cpu_wdata;
      tag1_d      = '{acc: cpu_we ? ACC_CPU_WR : ACC_CPU_RD, oor: !cpu_in_range, hit: 1'b0};
    end

    // tag2_q lines up with the cycle in which ram_rdata holds this access's data.
    case (tag2_q.acc)
      ACC_SCAN: begin
        scan_vld_d   = 1'b1;
        scan_data_d  = tag2_q.oor ? SPACE_CODE : ram_rdata;
        cursor_hit_d = tag2_q.hit;
      end
      ACC_CPU_RD: begin
        cpu_rvalid_d = 1'b1;
        cpu_rdata_d  = tag2_q.oor ? 8'h00 : ram_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      scan_pend_q    <= 1'b0;
      scan_addr_q    <= '0;
      scan_inr_q     <= 1'b0;
      scan_overrun_q <= 1'b0;
      ram_en_q       <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      cpu_gnt_q      <= 1'b0;
      tag1_q         <= TAG_IDLE;
      tag2_q         <= TAG_IDLE;
      scan_data_q    <= '0;
      scan_vld_q     <= 1'b0;
      cursor_hit_q   <= 1'b0;
      cpu_rdata_q    <= '0;
      cpu_rvalid_q   <= 1'b0;
    end else begin
      scan_pend_q    <= scan_pend_d;
      scan_addr_q    <= scan_addr_d;
      scan_inr_q     <= scan_inr_d;
      scan_overrun_q <= scan_overrun_d;
      ram_en_q       <= ram_en_d;
      ram_we_q       <= ram_we_d;
      ram_addr_q     <= ram_addr_d;
      ram_wdata_q    <= ram_wdata_d;
      cpu_gnt_q      <= cpu_gnt_d;
      tag1_q         <= tag1_d;
      tag2_q         <= tag2_d;
      scan_data_q    <= scan_data_d;
      scan_vld_q     <= scan_vld_d;
      cursor_hit_q   <= cursor_hit_d;
      cpu_rdata_q    <= cpu_rdata_d;
      cpu_rvalid_q   <= cpu_rvalid_d;
    end
  end

  assign scan_data    = scan_data_q;
  assign scan_vld     = scan_vld_q;
  assign cursor_hit   = cursor_hit_q;
  assign scan_overrun = scan_overrun_q;
  assign cpu_gnt      = cpu_gnt_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_rvalid   = cpu_rvalid_q;
  assign ram_en       = ram_en_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter with a behavioural single-port VRAM
// (read data one cycle after ram_en).
module tb_vga_vram_arbiter;

  localparam int ADDR_W = 12;

  logic              pclk = 1'b0;
  logic              reset;
  logic              scan_req;
  logic [4:0]        scan_row;
  logic [6:0]        scan_col;
  logic [7:0]        scan_data;
  logic              scan_vld, cursor_hit, scan_overrun;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_gnt;
  logic [7:0]        cpu_rdata;
  logic              cpu_rvalid;
  logic [ADDR_W-1:0] cursor_pos;
  logic              frame_start;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:4095];

  vga_vram_arbiter dut (
    .pclk         (pclk),
    .reset        (reset),
    .scan_req     (scan_req),
    .scan_row     (scan_row),
    .scan_col     (scan_col),
    .scan_data    (scan_data),
    .scan_vld     (scan_vld),
    .cursor_hit   (cursor_hit),
    .scan_overrun (scan_overrun),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_gnt      (cpu_gnt),
    .cpu_rdata    (cpu_rdata),
    .cpu_rvalid   (cpu_rvalid),
    .cursor_pos   (cursor_pos),
    .frame_start  (frame_start),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #20 pclk = ~pclk;

  always @(posedge pclk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {scan_data, scan_vld, cursor_hit, scan_overrun, cpu_gnt, cpu_rdata,
                cpu_rvalid, ram_en, ram_we, ram_addr, ram_wdata}, 64'h0);
  endtask

  // Scan with idle CPU: RAM issue one cycle after scan_req, data three cycles after.
  task automatic scan_chk(input string tag, input logic [4:0] row, input logic [6:0] col,
                          input logic exp_en, input logic [11:0] exp_addr,
                          input logic [7:0] exp_data, input logic exp_hit);
    scan_row = row;
    scan_col = col;
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
    check({tag, ".en_n"}, ram_en, 1'b0);
    tick();
    check({tag, ".en_n1"}, ram_en, exp_en);
    check({tag, ".we_n1"}, ram_we, 1'b0);
    if (exp_en) check({tag, ".addr_n1"}, ram_addr, exp_addr);
    tick();
    check({tag, ".vld_n2"}, scan_vld, 1'b0);
    tick();
    check({tag, ".vld_n3"}, scan_vld, 1'b1);
    check({tag, ".data_n3"}, scan_data, exp_data);
    check({tag, ".hit_n3"}, cursor_hit, exp_hit);
    tick();
    check({tag, ".vld_n4"}, scan_vld, 1'b0);
    check({tag, ".hit_n4"}, cursor_hit, 1'b0);
  endtask

  task automatic cpu_op(input string tag, input logic we, input logic [11:0] addr,
                        input logic [7:0] wdata, input logic exp_en, input logic [7:0] exp_rdata);
    int waited;
    waited   = 0;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_req   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (cpu_gnt) break;
      waited++;
    end
    check({tag, ".gnt"}, cpu_gnt, 1'b1);
    check({tag, ".wait"}, waited, 0);
    check({tag, ".en"}, ram_en, exp_en);
    check({tag, ".we"}, ram_we, we & exp_en);
    if (exp_en) check({tag, ".addr"}, ram_addr, addr);
    if (we && exp_en) check({tag, ".wdata"}, ram_wdata, wdata);
    cpu_req = 1'b0;
    if (!we) begin
      tick();
      check({tag, ".rvld_g1"}, cpu_rvalid, 1'b0);
      tick();
      check({tag, ".rvld_g2"}, cpu_rvalid, 1'b1);
      check({tag, ".rdata"}, cpu_rdata, exp_rdata);
    end
    tick();
    check({tag, ".gnt_off"}, cpu_gnt, 1'b0);
  endtask

  initial begin
    int vld_cnt, vld_at;
    logic [7:0] vld_data;
    logic seen;

    reset       = 1'b0;
    scan_req    = 1'b0;
    scan_row    = '0;
    scan_col    = '0;
    cpu_req     = 1'b0;
    cpu_we      = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    cursor_pos  = 12'd145;
    frame_start = 1'b0;

    tick();
    tick();
    check_all_zero("reset_outputs");
    reset = 1'b1;
    tick();

    // Preload cells through the CPU port.
    cpu_op("wr145", 1'b1, 12'd145, 8'h41, 1'b1, 8'h00);
    cpu_op("wr70",  1'b1, 12'd70,  8'h33, 1'b1, 8'h00);
    cpu_op("wr1",   1'b1, 12'd1,   8'h11, 1'b1, 8'h00);

    // row 2, col 5 -> 2*70+5 = 145; cursor still off.
    scan_chk("scan145", 5'd2, 7'd5, 1'b1, 12'd145, 8'h41, 1'b0);

    cpu_op("wr10", 1'b1, 12'd10, 8'h5A, 1'b1, 8'h00);
    cpu_op("rd10", 1'b0, 12'd10, 8'h00, 1'b1, 8'h5A);

    // Simultaneous scan_req and cpu_req: scan at N+1, CPU grant at N+2.
    scan_row  = 5'd2;
    scan_col  = 7'd5;
    scan_req  = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 12'd10;
    tick();
    scan_req = 1'b0;
    check("coll.gnt_n", cpu_gnt, 1'b0);
    check("coll.en_n", ram_en, 1'b0);
    tick();
    check("coll.gnt_n1", cpu_gnt, 1'b0);
    check("coll.en_n1", ram_en, 1'b1);
    check("coll.addr_n1", ram_addr, 12'd145);
    tick();
    check("coll.gnt_n2", cpu_gnt, 1'b1);
    check("coll.addr_n2", ram_addr, 12'd10);
    cpu_req = 1'b0;
    tick();
    check("coll.vld_n3", scan_vld, 1'b1);
    check("coll.sdata_n3", scan_data, 8'h41);
    check("coll.rvld_n3", cpu_rvalid, 1'b0);
    tick();
    check("coll.rvld_n4", cpu_rvalid, 1'b1);
    check("coll.rdata_n4", cpu_rdata, 8'h5A);
    check("coll.svld_n4", scan_vld, 1'b0);
    tick();

    // Out-of-range row and CPU address.
    scan_chk("scan_oor", 5'd31, 7'd0, 1'b0, 12'd0, 8'h20, 1'b0);
    scan_chk("scan_col70", 5'd0, 7'd70, 1'b0, 12'd0, 8'h20, 1'b0);
    cpu_op("wr2100", 1'b1, 12'd2100, 8'hAA, 1'b0, 8'h00);
    cpu_op("rd2100", 1'b0, 12'd2100, 8'h00, 1'b0, 8'h00);
    // Last cell is in range: 29*70+69 = 2099.
    cpu_op("wr2099", 1'b1, 12'd2099, 8'h7E, 1'b1, 8'h00);
    scan_chk("scan2099", 5'd29, 7'd69, 1'b1, 12'd2099, 8'h7E, 1'b0);

    // Back-to-back scan_req: overrun, single result for cell 70.
    check("ovr.before", scan_overrun, 1'b0);
    scan_row = 5'd0;
    scan_col = 7'd1;
    scan_req = 1'b1;
    tick();
    scan_row = 5'd1;
    scan_col = 7'd0;
    tick();
    scan_req = 1'b0;
    check("ovr.flag", scan_overrun, 1'b1);
    check("ovr.en_n1", ram_en, 1'b0);
    vld_cnt  = 0;
    vld_at   = -1;
    vld_data = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) begin
        check("ovr.en_n2", ram_en, 1'b1);
        check("ovr.addr_n2", ram_addr, 12'd70);
      end
      if (scan_vld) begin
        vld_cnt++;
        vld_at   = i;
        vld_data = scan_data;
      end
    end
    check("ovr.vld_count", vld_cnt, 1);
    check("ovr.vld_cycle", vld_at, 2);
    check("ovr.data", vld_data, 8'h33);
    check("ovr.sticky", scan_overrun, 1'b1);

    // Blink: 29 frames keeps cursor off, the 30th turns it on.
    for (int i = 0; i < 29; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
    scan_chk("blink29", 5'd2, 7'd5, 1'b1, 12'd145, 8'h41, 1'b0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    scan_chk("blink30", 5'd2, 7'd5, 1'b1, 12'd145, 8'h41, 1'b1);
    scan_chk("blink_other", 5'd0, 7'd70, 1'b0, 12'd0, 8'h20, 1'b0);
    scan_chk("blink_cell70", 5'd1, 7'd0, 1'b1, 12'd70, 8'h33, 1'b0);

    // Reset with a scan and a CPU read in flight.
    scan_row = 5'd2;
    scan_col = 7'd5;
    scan_req = 1'b1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 12'd10;
    tick();
    scan_req = 1'b0;
    tick();
    tick();
    check("rst.gnt_before", cpu_gnt, 1'b1);
    cpu_req = 1'b0;
    reset   = 1'b0;
    #1;
    check_all_zero("rst.outputs");
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | scan_vld | cpu_rvalid | ram_en | ram_we;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | scan_vld | cpu_rvalid | ram_en | ram_we;
    end
    check("rst.no_activity", seen, 1'b0);
    check("rst.overrun_clr", scan_overrun, 1'b0);
    // Cursor is off again after reset.
    scan_chk("rst.scan145", 5'd2, 7'd5, 1'b1, 12'd145, 8'h41, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
Shares one single-port character VRAM (COLS x ROWS cells, 8-bit char codes) between the VGA text scan path and a CPU-side bus. The scan path fetches one char code per 9-pixel cell and has strict priority; CPU reads and writes take the remaining RAM cycles through a req/gnt handshake. The block also runs the cursor blink counter and flags the cursor cell alongside returned scan data. It sits between the VGA timing/char-counter logic and the VRAM macro.

Parameters:
COLS, 70, characters per row
ROWS, 30, character rows
ADDR_W, 12, VRAM address width (COLS*ROWS must be <= 2**ADDR_W)
BLINK_FRAMES, 30, frames per cursor on/off phase
SPACE_CODE, 8'h20, char returned for out-of-range scan addresses

Ports:
pclk  input  1  pixel clock, 25 MHz; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
scan_req  input  1  one-cycle pulse: fetch char at scan_row/scan_col
scan_row  input  5  character row, 0..ROWS-1
scan_col  input  7  character column, 0..COLS-1
scan_data  output  8  fetched char code
scan_vld  output  1  one-cycle pulse: scan_data/cursor_hit valid
cursor_hit  output  1  returned cell is the cursor cell and cursor visible
scan_overrun  output  1  sticky: scan_req arrived while previous scan still pending
cpu_req  input  1  CPU access request; held until cpu_gnt
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  linear cell address
cpu_wdata  input  8  write data
cpu_gnt  output  1  one-cycle pulse: access issued to RAM this cycle
cpu_rdata  output  8  read data
cpu_rvalid  output  1  one-cycle pulse: cpu_rdata valid
cursor_pos  input  ADDR_W  linear cursor address
frame_start  input  1  one-cycle pulse per frame
ram_en  output  1  RAM access enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM address
ram_wdata  output  8  RAM write data
ram_rdata  input  8  RAM read data, valid 1 cycle after ram_en

Behaviour:
- Reset: all outputs 0; scan_pend, cpu pipeline tags, blink counter, cursor_on cleared.
- Scan capture (cycle N): scan_req registers addr = scan_row*COLS + scan_col (ADDR_W bits, unsigned) and in-range flag (row<ROWS && col<COLS); sets scan_pend.
- Issue stage, one RAM access per cycle, registered outputs:
  - scan_pend: drive ram_en=1, ram_we=0, ram_addr=scan addr (cycle N+1); clear scan_pend.
  - else cpu_req: ram_en=1, ram_we=cpu_we, ram_addr=cpu_addr, ram_wdata=cpu_wdata, cpu_gnt=1 the same cycle.
  - else ram_en=0.
- Scan return: ram_rdata sampled cycle N+2, scan_data/scan_vld registered at N+3 (fixed latency 3). Out-of-range: RAM not accessed, scan_data=SPACE_CODE, same latency.
- cursor_hit = (scan addr == cursor_pos) && cursor_on, aligned with scan_vld; 0 when not scan_vld.
- CPU read: cpu_rdata/cpu_rvalid registered 2 cycles after cpu_gnt. cpu_addr >= COLS*ROWS: gnt still given, write dropped (ram_en=0), read returns 8'h00.
- scan_req while scan_pend=1: new addr overwrites, scan_overrun set (cleared only by reset); single scan_vld for the newer request.
- scan_req and cpu_req same cycle: scan wins next cycle; CPU waits, cpu_gnt at earliest the following cycle. Scan_req arrives at most once per 9 cycles, so CPU waits at most 1 cycle.
- Blink: frame_start increments frame counter; at BLINK_FRAMES-1 wraps to 0 and toggles cursor_on.
- Reset mid-operation: in-flight scan_vld/cpu_rvalid suppressed; no RAM write after reset asserts.

Decomposition:
- Package vga_text_pkg: COLS, ROWS, ADDR_W, SPACE_CODE, CELL_W=9, CELL_H=16, access-type enum {ACC_NONE, ACC_SCAN, ACC_CPU_RD, ACC_CPU_WR} used for the 2-stage return tag pipeline.
- Sub-module vga_cursor_blink: frame counter + cursor_on toggle.

Test Plan:
- Scan row=2, col=5, RAM[145]=8'h41 -> ram_addr=145 at N+1, scan_data=8'h41 with scan_vld at N+3.
- CPU write addr 10 data 8'h5A, no scan -> cpu_gnt same cycle as ram_we=1; later CPU read addr 10 -> cpu_rvalid 2 cycles after gnt, rdata 8'h5A.
- scan_req and cpu_req same cycle -> scan issued at N+1, cpu_gnt at N+2; both complete with correct data.
- scan_row=31 -> no RAM access, scan_data=8'h20 at N+3; cpu write addr 2100 -> gnt, ram_en=0; read 2100 -> rdata 8'h00.
- Two scan_req on consecutive cycles -> scan_overrun=1, one scan_vld for second addr.
- cursor_pos=145, 30 frame_start pulses -> cursor_on toggles to 1; scan of 145 -> cursor_hit=1; reset low mid-read -> no scan_vld/cpu_rvalid, all outputs 0.
